biu_unit: RTL and testbench

BIU_UNIT -- requirements
Module: biu_unit

---
 rtl/biu_if.sv | 45 ++++
 rtl/biu_unit.sv | 174 +++++++++++++++++
 tb/tb_biu_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/biu_if.sv
// ---------------------------------------------------------------------------
// biu_if -- bundle of the bus-interface-unit signals.
//
// Decoder side   : cs_biu, sel_biu, ir (to BIU); ready_bus, err (from BIU)
// Register file  : rf_addr, rf_wdata, rf_we (from BIU); rf_rdata (to BIU,
//                  combinational from rf_addr)
// Memory         : mem_addr, mem_wdata, mem_re, mem_we (from BIU);
//                  mem_rdata, mem_ack (to BIU)
//
// Handshake: the decoder raises cs_biu with sel_biu/ir valid; the BIU
// captures them on the first rising edge where cs_biu=1 and answers with
// ready_bus (plus err) held until cs_biu is seen low.  Memory requests
// (mem_re / mem_we) are levels held until mem_ack=1 is sampled on clk.
//
// Modports: slave = the BIU itself, master = everything around it.
// ---------------------------------------------------------------------------
interface biu_if;
    logic        cs_biu;
    logic [1:0]  sel_biu;
    logic [31:0] ir;
    logic        ready_bus;
    logic        err;
    logic [3:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic        rf_we;
    logic [15:0] rf_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  cs_biu, sel_biu, ir, rf_rdata, mem_rdata, mem_ack,
        output ready_bus, err, rf_addr, rf_wdata, rf_we,
               mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output cs_biu, sel_biu, ir, rf_rdata, mem_rdata, mem_ack,
        input  ready_bus, err, rf_addr, rf_wdata, rf_we,
               mem_addr, mem_wdata, mem_re, mem_we
    );
endinterface

// File: rtl/biu_unit.sv
// ---------------------------------------------------------------------------
// biu_unit -- bus interface unit executing mov / load / store requests
// from the instruction decoder.
//
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   asynchronous active-high reset
//   bus      biu_if.slave  decoder, register-file and memory signals
//   state_o  out  current FSM state (debug visibility)
//
// Operations (captured from ir in IDLE):
//   mov   : reg[ir[13:10]] <= {8'h00, ir[7:0]}
//   load  : reg[ir[13:10]] <= mem[ir[7:0]]
//   store : mem[ir[7:0]]   <= reg[ir[13:10]]
// Memory accesses time out after 256 request cycles without mem_ack and
// complete with err=1; an illegal select completes with err=1 at once.
// All outputs are registers loaded from the next state, so they change
// only on clock edges (or reset).
// ---------------------------------------------------------------------------
module biu_unit (
    input  logic        clk,
    input  logic        rst,
    biu_if.slave        bus,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        MEM_RD = 3'd2,
        RF_RD  = 3'd3,
        MEM_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  addr_q, addr_d;
    logic        st_q, st_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        ready_q, rf_we_q, mem_re_q, mem_we_q;
    logic [3:0]  rf_addr_q;
    logic [15:0] rf_wdata_q, mem_wdata_q;
    logic [7:0]  mem_addr_q;

    // Instruction bits the BIU never looks at.
    logic ir_unused;
    assign ir_unused = ^{bus.ir[31:19], bus.ir[17:14], bus.ir[9:8], st_q};

    // Next-state and datapath decisions.  cs_biu is tested with an
    // if/else so that X or Z on it takes the "deasserted" branch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        st_d    = st_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.cs_biu == 1'b1) begin
                    st_d   = bus.ir[18];
                    idx_d  = bus.ir[13:10];
                    addr_d = bus.ir[7:0];
                    err_d  = 1'b0;
                    cnt_d  = 8'd0;
                    case (bus.sel_biu)
                        2'b00: begin
                            data_d  = {8'h00, bus.ir[7:0]};
                            state_d = WB;
                        end
                        2'b01: state_d = bus.ir[18] ? RF_RD : MEM_RD;
                        default: begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            WB: state_d = DONE;
            MEM_RD: begin
                // An ack on the last counted cycle still wins over timeout.
                if (bus.mem_ack == 1'b1) begin
                    data_d  = bus.mem_rdata;
                    state_d = WB;
                end else if (cnt_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RF_RD: begin
                data_d  = bus.rf_rdata;
                cnt_d   = 8'd0;
                state_d = MEM_WR;
            end
            MEM_WR: begin
                if (bus.mem_ack == 1'b1) begin
                    state_d = DONE;
                end else if (cnt_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (bus.cs_biu == 1'b1) begin
                    state_d = DONE;
                end else begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched fields and registered Moore outputs.  Outputs are
    // loaded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            addr_q      <= 8'd0;
            st_q        <= 1'b0;
            data_q      <= 16'd0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rf_addr_q   <= 4'd0;
            rf_wdata_q  <= 16'd0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            st_q        <= st_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            ready_q     <= (state_d == DONE);
            rf_we_q     <= (state_d == WB);
            mem_re_q    <= (state_d == MEM_RD);
            mem_we_q    <= (state_d == MEM_WR);
            rf_addr_q   <= (state_d == WB || state_d == RF_RD) ? idx_d : 4'd0;
            rf_wdata_q  <= (state_d == WB) ? data_d : 16'd0;
            mem_addr_q  <= (state_d == MEM_RD || state_d == MEM_WR) ? addr_d : 8'd0;
            mem_wdata_q <= (state_d == MEM_WR) ? data_d : 16'd0;
        end
    end

    assign bus.ready_bus = ready_q;
    assign bus.err       = err_q & ready_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_biu_unit.sv
// ---------------------------------------------------------------------------
// tb_biu_unit -- randomized bench for biu_unit.  Each operation is predicted
// from its architectural effect (latency, request cycle counts, register
// writes, err) and compared with what the bus shows cycle by cycle.
// Inputs are driven on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_biu_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_dbg;

    biu_if bus ();

    biu_unit dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] rf_mem [16];
    logic [19:0] exp_q [$];

    assign bus.rf_rdata = rf_mem[bus.rf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation; the caller must be just after a falling edge.
    // k = cycles the memory waits before mem_ack (k > 255 means never).
    task automatic run_op(input logic [1:0] sel, input logic st, input logic [3:0] idx,
                          input logic [7:0] a, input int k, input logic [15:0] rdata,
                          input bit hold_cs);
        int          exp_lat;
        logic        exp_err;
        int          exp_re;
        int          exp_we;
        logic [15:0] wd;
        logic [31:0] ir_v;
        logic [19:0] e;
        int          lat;
        int          re_cnt;
        int          we_cnt;
        int          req;

        exp_re = 0;
        exp_we = 0;
        wd     = rf_mem[idx];
        exp_q.delete();
        if (sel == 2'b00) begin
            exp_lat = 2;
            exp_err = 1'b0;
            exp_q.push_back({idx, 8'h00, a});
        end else if (sel == 2'b01 && !st) begin
            if (k > 255) begin
                exp_re = 256; exp_lat = 257; exp_err = 1'b1;
            end else begin
                exp_re = k + 1; exp_lat = 3 + k; exp_err = 1'b0;
                exp_q.push_back({idx, rdata});
            end
        end else if (sel == 2'b01) begin
            if (k > 255) begin
                exp_we = 256; exp_lat = 258; exp_err = 1'b1;
            end else begin
                exp_we = k + 1; exp_lat = 3 + k; exp_err = 1'b0;
            end
        end else begin
            exp_lat = 1;
            exp_err = 1'b1;
        end

        ir_v        = $urandom;
        ir_v[18]    = st;
        ir_v[13:10] = idx;
        ir_v[7:0]   = a;
        bus.cs_biu  = 1'b1;
        bus.sel_biu = sel;
        bus.ir      = ir_v;
        bus.mem_ack = 1'(($urandom_range(0, 1)));
        @(posedge clk);

        lat = 0; re_cnt = 0; we_cnt = 0; req = 0;
        for (int c = 1; c <= 300 && lat == 0; c++) begin
            @(negedge clk);
            bus.ir      = $urandom;
            bus.sel_biu = 2'($urandom_range(0, 3));
            if (!hold_cs) bus.cs_biu = 1'b0;
            if (bus.mem_re && bus.mem_we) chk("re_we_overlap", 1, 0);
            if (bus.mem_re) begin
                re_cnt++;
                if (bus.mem_addr !== a) chk("mem_addr_rd", bus.mem_addr, a);
            end
            if (bus.mem_we) begin
                we_cnt++;
                if (bus.mem_addr !== a) chk("mem_addr_wr", bus.mem_addr, a);
                if (bus.mem_wdata !== wd) chk("mem_wdata", bus.mem_wdata, wd);
            end
            if (bus.rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("rf_we_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_addr", bus.rf_addr, e[19:16]);
                    chk("rf_wdata", bus.rf_wdata, e[15:0]);
                end
            end
            if (bus.ready_bus) begin
                lat = c;
                chk("err", bus.err, exp_err);
            end
            // Memory responder; acks outside a request are noise to ignore.
            if (bus.mem_re || bus.mem_we) begin
                bus.mem_ack   = (req == k);
                bus.mem_rdata = (req == k) ? rdata : 16'($urandom);
                req++;
            end else begin
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
            end
        end
        if (lat == 0) chk("ready_timeout", 0, 1);
        chk("latency", lat, exp_lat);
        chk("mem_re_cycles", re_cnt, exp_re);
        chk("mem_we_cycles", we_cnt, exp_we);
        chk("rf_write_missing", exp_q.size(), 0);

        if (hold_cs) begin
            @(negedge clk);
            chk("ready_held", bus.ready_bus, 1);
            chk("err_held", bus.err, exp_err);
            bus.cs_biu = 1'b0;
        end
        @(negedge clk);
        chk("ready_drop", bus.ready_bus, 0);
        chk("err_drop", bus.err, 0);
        chk("rf_we_after", bus.rf_we, 0);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'($urandom);
        bus.cs_biu    = 1'b0;
        bus.sel_biu   = 2'b00;
        bus.ir        = 32'd0;
        bus.mem_rdata = 16'd0;
        bus.mem_ack   = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", state_dbg, 0);
        chk("rst_outputs", {bus.ready_bus, bus.err, bus.rf_we, bus.mem_re, bus.mem_we},  0);
        chk("rst_buses", {bus.rf_addr, bus.rf_wdata, bus.mem_addr, bus.mem_wdata}, 0);
        rst = 1'b0;

        // Directed cases; the mov right after reset release also checks
        // that the first edge with cs_biu=1 is the capture edge.
        run_op(2'b00, 1'b0, 4'd3, 8'hA5, 0, 16'h0, 1'b1);
        run_op(2'b01, 1'b0, 4'd5, 8'h10, 3, 16'h1234, 1'b1);
        rf_mem[7] = 16'hBEEF;
        run_op(2'b01, 1'b1, 4'd7, 8'h20, 0, 16'h0, 1'b1);
        run_op(2'b01, 1'b0, 4'd2, 8'h33, 999, 16'h5555, 1'b1);
        run_op(2'b01, 1'b1, 4'd9, 8'h44, 999, 16'h0, 1'b0);
        run_op(2'b01, 1'b0, 4'd1, 8'h55, 255, 16'hCAFE, 1'b0);
        run_op(2'b01, 1'b1, 4'd4, 8'h66, 255, 16'h0, 1'b1);
        run_op(2'b10, 1'b0, 4'd6, 8'h77, 0, 16'h0, 1'b1);
        run_op(2'b11, 1'b1, 4'd8, 8'h88, 0, 16'h0, 1'b0);
        run_op(2'b00, 1'b1, 4'd15, 8'hFF, 0, 16'h0, 1'b0);

        // Reset in the middle of a store's write phase, between edges.
        bus.cs_biu  = 1'b1;
        bus.sel_biu = 2'b01;
        bus.ir      = 32'h0004_0C20;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_we", bus.mem_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {bus.ready_bus, bus.err, bus.rf_we, bus.mem_re, bus.mem_we}, 0);
        chk("async_rst_buses", {bus.rf_addr, bus.rf_wdata, bus.mem_addr, bus.mem_wdata}, 0);
        chk("async_rst_state", state_dbg, 0);
        bus.cs_biu = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.rf_we || bus.mem_we || bus.mem_re) chk("quiet_after_rst", 1, 0);
        end
        chk("idle_after_rst", state_dbg, 0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] sel;
            int         k;
            sel = 2'($urandom_range(0, 3));
            if (sel >= 2'b10 && $urandom_range(0, 1) == 0) sel = 2'b01;
            case ($urandom_range(0, 9))
                0:       k = 255;
                1:       k = 400;
                default: k = $urandom_range(0, 6);
            endcase
            run_op(sel, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   8'($urandom), k, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
